// File: rtl/nibble_serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_rx_pkg
// Shared definitions for the nibble serial receiver:
//   - rx_state_t : receiver FSM state encodings (3-bit)
//   - DATA_BITS  : number of data bits carried by one frame
//   - is_busy()  : receiver activity decode (every state except IDLE)
// No ports (package).
// -----------------------------------------------------------------------------
package nibble_serial_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 4;

    // The receiver is considered active in every state except IDLE.
    function automatic logic is_busy(input rx_state_t state);
        return (state != ST_IDLE);
    endfunction

endpackage

// File: rtl/nibble_serial_rx_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset to 1 so that an idle-high serial line looks idle straight out of
// reset.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high reset (flops load 1)
//   d_in   in  asynchronous input
//   q_out  out synchronized copy of d_in (2 cycles of latency)
// -----------------------------------------------------------------------------
module bit_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_in,
    output logic q_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
        end
    end

    assign q_out = r_sync;

endmodule

// File: rtl/nibble_serial_rx.sv
// -----------------------------------------------------------------------------
// nibble_serial_rx
// Receives frames of the form: start(0), a, b, c, d, stop(1) on an idle-high
// serial line and presents the recovered 4-bit word on a..d with a one-cycle
// ready strobe. False starts are dropped silently; a low stop bit produces a
// one-cycle frame_err pulse and leaves a..d untouched.
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (2..255)
//   CNT_W         bit-period counter width (must hold CLKS_PER_BIT-1)
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   serial_in  in   asynchronous serial line, idle high
//   a,b,c,d    out  data bits of the last good frame (first..fourth)
//   ready      out  one-cycle pulse, a..d hold a new word
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   busy       out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module nibble_serial_rx
    import nibble_serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic serial_in,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic ready,
    output logic frame_err,
    output logic busy
);

    // The counter runs down to zero, so a load of L expires L+1 cycles later.
    // Loading (period - 1) keeps every value within CLKS_PER_BIT-1.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       LAST_IDX  = 2'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_cnt_expired;

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] r_word;
    logic [DATA_BITS-1:0] w_word_next;
    logic                 r_ready;
    logic                 w_ready_next;
    logic                 r_frame_err;
    logic                 w_frame_err_next;

    bit_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d_in  (serial_in),
        .q_out (w_rx_s)
    );

    assign w_cnt_expired = (r_cnt == '0);

    // State, counters, shift register and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_word      <= '0;
            r_ready     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_shift     <= w_shift_next;
            r_word      <= w_word_next;
            r_ready     <= w_ready_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = w_cnt_expired ? '0 : (r_cnt - CNT_W'(1));
        w_idx_next       = r_idx;
        w_shift_next     = r_shift;
        w_word_next      = r_word;
        w_ready_next     = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                    w_cnt_next   = HALF_LOAD;
                end
            end

            // Re-check the line in the middle of the start bit to reject glitches.
            ST_START: begin
                if (w_cnt_expired) begin
                    if (w_rx_s) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                        w_idx_next   = '0;
                        w_cnt_next   = BIT_LOAD;
                    end
                end
            end

            ST_DATA: begin
                if (w_cnt_expired) begin
                    w_shift_next[r_idx] = w_rx_s;
                    w_cnt_next          = BIT_LOAD;
                    if (r_idx == LAST_IDX) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                    end
                end
            end

            // Returning straight to IDLE lets a start bit that immediately
            // follows the stop bit be caught with no gap.
            ST_STOP: begin
                if (w_cnt_expired) begin
                    if (w_rx_s) begin
                        w_word_next  = r_shift;
                        w_ready_next = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = ST_WAIT_IDLE;
                    end
                end
            end

            // A line stuck low after a framing error must not look like a new start.
            ST_WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign a         = r_word[0];
    assign b         = r_word[1];
    assign c         = r_word[2];
    assign d         = r_word[3];
    assign ready     = r_ready;
    assign frame_err = r_frame_err;
    assign busy      = is_busy(r_state);

endmodule
